// File: rtl/split_bus_arbiter_pkg.sv
// Shared definitions for the split-transaction bus arbiter: FSM state encoding
// and master-select constants.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN    = 2'd1,
      RESUME = 2'd2,
      TURN   = 2'd3
   } arb_state_t;

   localparam logic OWNER_M1 = 1'b0;
   localparam logic OWNER_M2 = 1'b1;

endpackage

// File: rtl/split_bus_arbiter_split_tracker.sv
// Tracks the single outstanding split: edge-detects s_split, records which
// master was parked, and raises resume_pending once the slave is ready again.
module split_tracker
   import arb_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic s_split,
   input  logic msel,
   input  logic own_active,
   input  logic resume_start,
   output logic split_enter,
   output logic split_owner,
   output logic m1_split,
   output logic m2_split,
   output logic resume_pending
);

   logic s_split_q;
   logic split_rise;
   logic split_fall;
   logic outstanding;

   assign split_rise  = s_split & ~s_split_q;
   assign split_fall  = ~s_split & s_split_q;
   assign outstanding = m1_split | m2_split | resume_pending;
   // Only a stall raised against a live OWN transfer starts a split; anything else is noise.
   assign split_enter = split_rise & own_active & ~outstanding;

   // NOTE: the synchronous reset sits inside the clocked block so every register clears on the same edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s_split_q      <= 1'b0;
         split_owner    <= OWNER_M1;
         m1_split       <= 1'b0;
         m2_split       <= 1'b0;
         resume_pending <= 1'b0;
      end else begin
         s_split_q <= s_split;
         if (split_enter) begin
            split_owner <= msel;
            if (msel == OWNER_M1) m1_split <= 1'b1;
            else                  m2_split <= 1'b1;
         end else if (resume_start) begin
            resume_pending <= 1'b0;
            if (split_owner == OWNER_M1) m1_split <= 1'b0;
            else                         m2_split <= 1'b0;
         end
         if (split_fall && (m1_split || m2_split) && !resume_start)
            resume_pending <= 1'b1;
      end
   end

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-master bus arbiter with split-transaction parking/resume for one slave.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests.
module split_bus_arbiter
   import arb_pkg::*;
#(
   parameter int TURNAROUND_CYCLES = 1,
   parameter int TURN_CNT_W        = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic m1_breq,
   input  logic m2_breq,
   input  logic s_split,
   output logic m1_bgrant,
   output logic m2_bgrant,
   output logic m1_split,
   output logic m2_split,
   output logic split_grant,
   output logic msel,
   output logic bus_busy
);

   localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURNAROUND_CYCLES - 1);

   arb_state_t            state;
   logic [TURN_CNT_W-1:0] turn_cnt;
   logic                  split_enter;
   logic                  split_owner;
   logic                  resume_pending;
   logic                  owner_req;
   logic                  elig1;
   logic                  elig2;
   logic                  pick;
   logic                  resume_start;

   assign owner_req    = (msel == OWNER_M1) ? m1_breq : m2_breq;
   assign elig1        = m1_breq & ~m1_split;
   assign elig2        = m2_breq & ~m2_split;
   assign resume_start = (state == IDLE) & resume_pending;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_owner;

   assign pick = (elig1 && elig2) ? ~last_owner : (elig1 ? OWNER_M1 : OWNER_M2);

   always_ff @(posedge clk) begin
      if (!rstn)
         last_owner <= OWNER_M2;
      else if (resume_start)
         last_owner <= split_owner;
      else if (state == IDLE && (elig1 || elig2))
         last_owner <= pick;
   end
`else
   assign pick = elig1 ? OWNER_M1 : OWNER_M2;
`endif

   split_tracker u_split_tracker (
      .clk            (clk),
      .rstn           (rstn),
      .s_split        (s_split),
      .msel           (msel),
      .own_active     (state == OWN),
      .resume_start   (resume_start),
      .split_enter    (split_enter),
      .split_owner    (split_owner),
      .m1_split       (m1_split),
      .m2_split       (m2_split),
      .resume_pending (resume_pending)
   );

   // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         turn_cnt    <= '0;
         m1_bgrant   <= 1'b0;
         m2_bgrant   <= 1'b0;
         split_grant <= 1'b0;
         msel        <= OWNER_M1;
         bus_busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A parked master waiting on its slave outranks fresh requests.
               if (resume_pending) begin
                  msel        <= split_owner;
                  m1_bgrant   <= (split_owner == OWNER_M1);
                  m2_bgrant   <= (split_owner == OWNER_M2);
                  split_grant <= 1'b1;
                  bus_busy    <= 1'b1;
                  state       <= RESUME;
               end else if (elig1 || elig2) begin
                  msel      <= pick;
                  m1_bgrant <= (pick == OWNER_M1);
                  m2_bgrant <= (pick == OWNER_M2);
                  bus_busy  <= 1'b1;
                  state     <= OWN;
               end
            end
            OWN, RESUME: begin
               if (split_enter || !owner_req) begin
                  m1_bgrant   <= 1'b0;
                  m2_bgrant   <= 1'b0;
                  split_grant <= 1'b0;
                  bus_busy    <= 1'b0;
                  turn_cnt    <= TURN_LOAD;
                  state       <= TURN;
               end
            end
            TURN: begin
               if (turn_cnt == '0) state <= IDLE;
               else                turn_cnt <= turn_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
